mem_arbiter: RTL and testbench

- Shares the single-ported cache/memory system (Addr/DataIn/Rd/Wr in; DataOut/Done/Stall/CacheHit/err out) between the instruction-fetch port (read-only) and the data port (read/write).
- Latches one request at a time and holds it stable on the memory side until Done.
- Routes the response back to the owning requester and stalls the other requester.
- Sits between fetch/memory pipeline stages and mem_system; also keeps saturating hit/miss statistics.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/sat_counter.sv | 18 +
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_MAX_D_STREAK = 4;
  localparam int DEF_TIMEOUT      = 64;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic owner_e owner_of(input state_e s);
    return (s == BUSY_D) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (read-only) and data (read/write) ports onto one
// mem_system port, one latched transaction at a time, with hit/miss stats.
//
// state  | meaning
// IDLE   | no transaction; grant decided at the next edge
// BUSY_I | fetch read in flight, memory driven from latched request
// BUSY_D | data read/write in flight, memory driven from latched request
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data_out,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_in,
  output logic [DATA_W-1:0] d_data_out,
  output logic              d_done,
  output logic              d_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              mem_cache_hit,
  input  logic              mem_err,
  output logic              err,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [TMR_W-1:0]    TMR_LOAD   = TMR_W'(TIMEOUT - 1);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rd_q, wr_q;
  logic [STREAK_W-1:0] streak;
  logic [TMR_W-1:0]    tmr;
  logic                err_q;
  logic                d_req, d_illegal, grant_d, grant_i;
  logic                busy, complete, timed_out;
  logic                unused;

  // mem_stall only mirrors !mem_done while busy; completion is keyed off mem_done.
  assign unused = mem_stall;

  assign d_req     = d_rd ^ d_wr;
  assign d_illegal = d_rd & d_wr;
  assign busy      = (state != IDLE);
  assign grant_d   = !busy && d_req && (!i_rd || (streak < STREAK_MAX));
  assign grant_i   = !busy && !grant_d && i_rd;
  assign complete  = busy && mem_done;
  assign timed_out = busy && !mem_done && (tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (complete || timed_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    i_data_out  = '0;
    d_data_out  = '0;
    if (busy) begin
      mem_addr    = addr_q;
      mem_data_in = wdata_q;
      mem_rd      = rd_q;
      mem_wr      = wr_q;
      if (owner_of(state) == OWN_D) begin
        d_done     = mem_done;
        d_data_out = mem_data_out;
      end else begin
        i_done     = mem_done;
        i_data_out = mem_data_out;
      end
    end
  end

  assign i_stall = i_rd & ~i_done;
  assign d_stall = (d_rd | d_wr) & ~d_done;
  assign err     = err_q;

  // Streak counts D grants that jumped a waiting fetch; any other grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      streak  <= '0;
      tmr     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant_d) begin
        addr_q  <= d_addr;
        wdata_q <= d_data_in;
        rd_q    <= d_rd;
        wr_q    <= d_wr;
        streak  <= i_rd ? streak + STREAK_W'(1) : '0;
        tmr     <= TMR_LOAD;
      end else if (grant_i) begin
        addr_q  <= i_addr;
        wdata_q <= '0;
        rd_q    <= 1'b1;
        wr_q    <= 1'b0;
        streak  <= '0;
        tmr     <= TMR_LOAD;
      end else if (busy && (tmr != '0)) begin
        tmr <= tmr - TMR_W'(1);
      end
      if ((!busy && d_illegal) || (busy && mem_err) || timed_out)
        err_q <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (complete && mem_cache_hit),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (complete && !mem_cache_hit),
    .count (miss_count)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model, with a simple cache/memory responder.
module tb_mem_arbiter;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int MAX_D_STREAK = 4;
  localparam int TIMEOUT      = 64;
  localparam int CNT_W        = 4;

  logic              clk, rst_n;
  logic              i_rd, i_done, i_stall;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data_out;
  logic              d_rd, d_wr, d_done, d_stall;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data_in, d_data_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              mem_rd, mem_wr, mem_done, mem_stall, mem_cache_hit, mem_err;
  logic              err;
  logic [CNT_W-1:0]  hit_count, miss_count;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAX_D_STREAK),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd(i_rd), .i_addr(i_addr), .i_data_out(i_data_out), .i_done(i_done), .i_stall(i_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_cache_hit(mem_cache_hit), .mem_err(mem_err),
    .err(err), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] gold    [logic [ADDR_W-1:0]];
  bit                cached  [logic [ADDR_W-1:0]];
  int mem_age   = 0;
  int miss_lat  = 3;
  bit hit_now   = 1'b0;
  bit mem_hang  = 1'b0;
  bit rand_mode = 1'b0;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return a ^ 16'h5a5a;
  endfunction

  function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction

  function automatic logic [DATA_W-1:0] gold_read(input logic [ADDR_W-1:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  // One clock: respond as mem_system at the falling edge, then leave outputs settled for checks.
  task automatic cycle();
    bit done;
    @(negedge clk);
    done    = 1'b0;
    mem_err = 1'b0;
    if (mem_rd || mem_wr) begin
      if (mem_age == 0) begin
        hit_now  = cached.exists(mem_addr);
        miss_lat = rand_mode ? int'($urandom_range(2, 5)) : 3;
      end
      mem_age++;
      done = !mem_hang && (hit_now || (mem_age >= miss_lat));
      if (rand_mode && ($urandom_range(0, 31) == 0)) mem_err = 1'b1;
      mem_done      = done;
      mem_cache_hit = done && hit_now;
      mem_data_out  = done ? mem_read(mem_addr) : DATA_W'($urandom);
      mem_stall     = !done;
    end else begin
      mem_age       = 0;
      mem_done      = rand_mode && ($urandom_range(0, 15) == 0);
      mem_cache_hit = 1'($urandom_range(0, 1));
      mem_data_out  = DATA_W'($urandom);
      mem_stall     = 1'b0;
    end
    #1;
    if (done) begin
      if (mem_wr) mem_arr[mem_addr] = mem_data_in;
      cached[mem_addr] = 1'b1;
      mem_age = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_rd = 1'b0; i_addr = '0; d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_data_in = '0;
    mem_done = 1'b0; mem_err = 1'b0; mem_cache_hit = 1'b0; mem_stall = 1'b0; mem_data_out = '0;
    mem_age = 0; mem_hang = 1'b0; rand_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_rd, mem_wr} !== 2'b00) begin
      errors++; $display("FAIL reset_mem_op: got rd=%b wr=%b, want 0 0", mem_rd, mem_wr);
    end
    checks++;
    if ({i_done, d_done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got i_done=%b d_done=%b err=%b, want 0 0 0", i_done, d_done, err);
    end
    checks++;
    if (hit_count !== '0 || miss_count !== '0) begin
      errors++; $display("FAIL reset_counts: got hit=%0d miss=%0d, want 0 0", hit_count, miss_count);
    end
    checks++;
    if (mem_addr !== '0) begin
      errors++; $display("FAIL reset_mem_addr: got %h, want 0000", mem_addr);
    end
  endtask

  task automatic test_write_miss();
    int busy_n = 0, stall_bad = 0;
    bit seen = 1'b0;
    d_wr = 1'b1; d_addr = 16'h1234; d_data_in = 16'hdead;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (k == 0) begin
        checks++;
        if ({mem_wr, mem_rd} !== 2'b10 || mem_addr !== 16'h1234 || mem_data_in !== 16'hdead) begin
          errors++;
          $display("FAIL wr_issue: got wr=%b rd=%b addr=%h data=%h, want 1 0 1234 dead",
                   mem_wr, mem_rd, mem_addr, mem_data_in);
        end
      end
      if (mem_wr) busy_n++;
      if (d_done === 1'b1) begin seen = 1'b1; break; end
      if (d_stall !== 1'b1) stall_bad++;
    end
    d_wr = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL wr_done: got no d_done in 100 cycles, want one"); end
    checks++;
    if (busy_n != 3) begin errors++; $display("FAIL wr_latency: got %0d busy cycles, want 3", busy_n); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL wr_stall: got %0d cycles without d_stall, want 0", stall_bad); end
    cycle();
    checks++;
    if (d_done !== 1'b0 || d_stall !== 1'b0) begin
      errors++; $display("FAIL wr_pulse: got d_done=%b d_stall=%b after done, want 0 0", d_done, d_stall);
    end
    checks++;
    if (miss_count !== CNT_W'(1) || hit_count !== '0) begin
      errors++; $display("FAIL wr_counts: got hit=%0d miss=%0d, want 0 1", hit_count, miss_count);
    end
  endtask

  task automatic test_read_hit();
    d_rd = 1'b1; d_addr = 16'h1234;
    cycle();
    checks++;
    if (d_done !== 1'b1 || d_data_out !== 16'hdead) begin
      errors++; $display("FAIL rd_hit: got d_done=%b data=%h, want 1 dead", d_done, d_data_out);
    end
    d_rd = 1'b0;
    cycle();
    checks++;
    if (hit_count !== CNT_W'(1) || d_done !== 1'b0) begin
      errors++; $display("FAIL rd_hit_count: got hit=%0d d_done=%b, want 1 0", hit_count, d_done);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    d_rd = 1'b1; d_addr = 16'h0777;
    cycle();
    cycle();
    checks++;
    if (mem_rd !== 1'b1) begin errors++; $display("FAIL mid_pre: got mem_rd=%b, want 1", mem_rd); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd, mem_wr, d_done} !== 3'b000) begin
      errors++; $display("FAIL mid_drop: got rd=%b wr=%b d_done=%b, want 0 0 0", mem_rd, mem_wr, d_done);
    end
    checks++;
    if (hit_count !== '0 || miss_count !== '0) begin
      errors++; $display("FAIL mid_counts: got hit=%0d miss=%0d, want 0 0", hit_count, miss_count);
    end
    d_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_age = 0;
    #1;
    i_rd = 1'b1; i_addr = 16'h0050;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (k == 0) begin
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0050) begin
          errors++; $display("FAIL mid_regrant: got rd=%b addr=%h, want 1 0050", mem_rd, mem_addr);
        end
      end
      if (i_done === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || i_data_out !== init_val(16'h0050)) begin
      errors++; $display("FAIL mid_fetch: got done=%b data=%h, want 1 %h", seen, i_data_out, init_val(16'h0050));
    end
    i_rd = 1'b0;
    cycle();
  endtask

  task automatic test_streak();
    bit got[$];
    bit exp_order[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit prev = 1'b0;
    int stall_bad = 0;
    do_reset();
    i_rd = 1'b1; i_addr = 16'h0100;
    d_rd = 1'b1; d_addr = 16'h0200;
    for (int k = 0; k < 400 && got.size() < 10; k++) begin
      cycle();
      if (mem_rd && !prev) got.push_back(mem_addr == 16'h0200);
      if (mem_rd && mem_addr == 16'h0200 && i_stall !== 1'b1) stall_bad++;
      prev = mem_rd;
    end
    checks++;
    if (got.size() != 10) begin
      errors++; $display("FAIL streak_count: got %0d grants, want 10", got.size());
    end
    for (int g = 0; g < got.size(); g++) begin
      checks++;
      if (got[g] != exp_order[g]) begin
        errors++; $display("FAIL streak_order[%0d]: got %s, want %s", g, got[g] ? "D" : "I", exp_order[g] ? "D" : "I");
      end
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL streak_i_stall: got %0d D cycles without i_stall, want 0", stall_bad); end
    i_rd = 1'b0; d_rd = 1'b0;
  endtask

  task automatic test_illegal();
    bit seen = 1'b0, d_seen = 1'b0;
    do_reset();
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0099;
    i_rd = 1'b1; i_addr = 16'h0040;
    cycle();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got err=%b, want 1", err); end
    checks++;
    if ({mem_rd, mem_wr} !== 2'b10 || mem_addr !== 16'h0040) begin
      errors++; $display("FAIL illegal_igrant: got rd=%b wr=%b addr=%h, want 1 0 0040", mem_rd, mem_wr, mem_addr);
    end
    for (int k = 0; k < 50; k++) begin
      if (d_done === 1'b1) d_seen = 1'b1;
      if (i_done === 1'b1) begin seen = 1'b1; break; end
      cycle();
    end
    checks++;
    if (!seen || d_seen) begin
      errors++; $display("FAIL illegal_done: got i_done=%b d_done_seen=%b, want 1 0", seen, d_seen);
    end
    i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    cycle();
  endtask

  task automatic test_timeout();
    int busy_n = 0;
    bit idone_seen = 1'b0;
    do_reset();
    mem_hang = 1'b1;
    i_rd = 1'b1; i_addr = 16'h0300;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (i_done === 1'b1) idone_seen = 1'b1;
      if (mem_rd) busy_n++;
      else if (busy_n > 0) break;
    end
    checks++;
    if (busy_n != TIMEOUT) begin errors++; $display("FAIL timeout_len: got %0d busy cycles, want %0d", busy_n, TIMEOUT); end
    checks++;
    if (err !== 1'b1 || {mem_rd, mem_wr} !== 2'b00) begin
      errors++; $display("FAIL timeout_abort: got err=%b rd=%b wr=%b, want 1 0 0", err, mem_rd, mem_wr);
    end
    checks++;
    if (idone_seen) begin errors++; $display("FAIL timeout_nodone: got i_done pulse, want none"); end
    i_rd = 1'b0;
    mem_hang = 1'b0;
    cycle();
  endtask

  // Randomized traffic; model tracks owner, age, streak and stats per transaction.
  task automatic test_random();
    int m_own = 0, m_age = 0, m_streak = 0, m_hits = 0, m_miss = 0;
    int sat = (1 << CNT_W) - 1;
    bit m_err = 1'b0, m_rd = 1'b0, was_idle, exp_rd, exp_wr, exp_id, exp_dd;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      cycle();
      exp_rd = (m_own == 1) || (m_own == 2 && m_rd);
      exp_wr = (m_own == 2) && !m_rd;
      exp_id = (m_own == 1) && mem_done;
      exp_dd = (m_own == 2) && mem_done;
      checks++;
      if ({mem_rd, mem_wr} !== {exp_rd, exp_wr}) begin
        errors++; $display("FAIL rnd_mem_op@%0d: got rd=%b wr=%b, want %b %b", n, mem_rd, mem_wr, exp_rd, exp_wr);
      end
      if (m_own != 0) begin
        checks++;
        if (mem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h, want %h", n, mem_addr, m_addr); end
      end
      if (exp_wr) begin
        checks++;
        if (mem_data_in !== m_wdata) begin errors++; $display("FAIL rnd_wdata@%0d: got %h, want %h", n, mem_data_in, m_wdata); end
      end
      checks++;
      if ({i_done, d_done} !== {exp_id, exp_dd}) begin
        errors++; $display("FAIL rnd_done@%0d: got i=%b d=%b, want %b %b", n, i_done, d_done, exp_id, exp_dd);
      end
      if (exp_id) begin
        checks++;
        if (i_data_out !== gold_read(m_addr)) begin
          errors++; $display("FAIL rnd_i_data@%0d: got %h, want %h", n, i_data_out, gold_read(m_addr));
        end
      end
      if (exp_dd && m_rd) begin
        checks++;
        if (d_data_out !== gold_read(m_addr)) begin
          errors++; $display("FAIL rnd_d_data@%0d: got %h, want %h", n, d_data_out, gold_read(m_addr));
        end
      end
      checks++;
      if ({i_stall, d_stall} !== {i_rd && !exp_id, (d_rd || d_wr) && !exp_dd}) begin
        errors++; $display("FAIL rnd_stall@%0d: got i=%b d=%b", n, i_stall, d_stall);
      end
      checks++;
      if (err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b, want %b", n, err, m_err); end
      checks++;
      if (hit_count !== CNT_W'(m_hits) || miss_count !== CNT_W'(m_miss)) begin
        errors++; $display("FAIL rnd_counts@%0d: got hit=%0d miss=%0d, want %0d %0d", n, hit_count, miss_count, m_hits, m_miss);
      end

      was_idle = (m_own == 0);
      if (!was_idle) begin
        if (mem_err) m_err = 1'b1;
        if (mem_done) begin
          if (mem_cache_hit) begin if (m_hits < sat) m_hits++; end
          else begin if (m_miss < sat) m_miss++; end
          if (m_own == 2 && !m_rd) gold[m_addr] = m_wdata;
          m_own = 0;
        end else if (m_age >= TIMEOUT) begin
          m_err = 1'b1;
          m_own = 0;
        end else begin
          m_age++;
        end
      end

      if (i_done) i_rd = 1'b0;
      if (d_done) begin d_rd = 1'b0; d_wr = 1'b0; end
      if (!i_rd && ($urandom_range(0, 2) == 0)) begin
        i_rd = 1'b1; i_addr = 16'h0010 + ADDR_W'($urandom_range(0, 7));
      end
      if (!d_rd && !d_wr && ($urandom_range(0, 2) == 0)) begin
        if ($urandom_range(0, 1) == 0) d_rd = 1'b1; else d_wr = 1'b1;
        d_addr = 16'h0010 + ADDR_W'($urandom_range(0, 7));
        d_data_in = DATA_W'($urandom);
      end

      if (was_idle) begin
        if (d_rd && d_wr) m_err = 1'b1;
        if ((d_rd ^ d_wr) && (!i_rd || m_streak < MAX_D_STREAK)) begin
          m_own = 2; m_rd = d_rd; m_addr = d_addr; m_wdata = d_data_in; m_age = 1;
          m_streak = i_rd ? m_streak + 1 : 0;
        end else if (i_rd) begin
          m_own = 1; m_addr = i_addr; m_age = 1; m_streak = 0;
        end
      end
    end
    rand_mode = 1'b0;
    i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_miss();
    test_read_hit();
    test_reset_mid();
    test_streak();
    test_illegal();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by 2 ms, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
